// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the program-counter fetch path.
// Default widths and the reset level used by every block here.
package pc_fetch_unit_pkg;

  localparam int   DEF_ADDR_W   = 8;
  localparam int   DEF_DATA_W   = 16;
  localparam logic RESET_ACTIVE = 1'b0;

endpackage

// File: rtl/pc_fetch_unit_fifo.sv
// Small synchronous queue holding fetched {pc, word} pairs.
// Head is read straight from storage; clear empties it in one cycle.
module sync_fifo
  import pc_fetch_unit_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam logic [PW-1:0] P_ONE  = 1;
  localparam logic [CW-1:0] C_ONE  = 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == C_FULL);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy next state; clear wins over push/pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + P_ONE;
      if (do_pop)  rd_d = rd_q + P_ONE;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + C_ONE;
        2'b01:   cnt_d = cnt_q - C_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Storage and pointers; reset zeroes storage so the head reads 0.
  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push && !clear) mem_q[wr_q] <= wdata;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch address counter, in-order memory reads and decode handoff.
// Redirects flush the queue and squash every read still in flight.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [OW-1:0]     O_ONE = 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [OW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     count;
  logic              empty, full;
  logic              credit, issue, push, pop;
  logic [ADDR_W+DATA_W-1:0] head;

  // Reads in flight count against queue space so it cannot overflow.
  assign credit = (int'(outst_q) < MAX_OUTST)
                & (int'(outst_q) + int'(count) < DEPTH)
                & ~full;
  assign req_valid  = (reset != RESET_ACTIVE) & ~redirect_valid & credit;
  assign req_addr   = fetch_pc_q;
  assign issue      = req_valid & req_ready;
  assign push       = resp_valid & ~redirect_valid & (drop_q == '0);
  assign inst_valid = ~empty;
  assign pop        = inst_valid & inst_ready & ~redirect_valid;
  assign inst_pc    = head[ADDR_W+DATA_W-1:DATA_W];
  assign inst_data  = head[DATA_W-1:0];

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({resp_pc_q, resp_data}),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Counter next state. On redirect every read still outstanding
  // (older squashed ones included) becomes a drop, less the one
  // returning right now.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (issue) begin
      fetch_pc_d = fetch_pc_q + A_ONE;
      outst_d    = outst_d + O_ONE;
    end
    if (resp_valid && outst_q != '0) outst_d = outst_d - O_ONE;
    if (resp_valid && drop_q != '0)  drop_d  = drop_q - O_ONE;
    if (push) resp_pc_d = resp_pc_q + A_ONE;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_d     = outst_d;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      fetch_pc_q <= '0;
      resp_pc_q  <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  a_resp_has_outst: assert property (
    @(posedge clk) disable iff (reset == RESET_ACTIVE)
    resp_valid |-> (outst_q != '0)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit with a tagged memory model and a
// transaction-level queue model checked every cycle.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic        resp_valid = 1'b0;
  logic [15:0] resp_data = '0;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_data;
  logic [7:0]  inst_pc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] pc;
    int         ep;
    int         due;
  } mreq_t;

  mreq_t      mq[$];
  logic [7:0] q[$];
  logic [7:0] got[$];
  logic [7:0] m_fetch = '0;
  int         epoch = 0;
  int         cyc   = 0;
  int         lat   = 1;
  bit         hold  = 1'b0;
  bit         armed = 1'b0;
  int         mark  = 0;

  pc_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(logic [7:0] a);
    return {a ^ 8'hC3, a + 8'd7};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] g(int i);
    if (mark + i < got.size()) return got[mark + i];
    return 8'hxx;
  endfunction

  // Memory plus reference model; every edge's effect is applied here
  // from the inputs and expected handshakes of the cycle just ending.
  always @(negedge clk) begin
    bit    erv, acc, rsp, pop;
    mreq_t e;
    e   = '{pc: 8'h00, ep: 0, due: 0};
    erv = reset && !redirect_valid && mq.size() < 2
          && mq.size() + q.size() < 4;
    if (armed) begin
      chk("req_valid", {31'd0, req_valid}, {31'd0, erv});
      if (erv) chk("req_addr", {24'd0, req_addr}, {24'd0, m_fetch});
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
        chk("inst_pc", {24'd0, inst_pc}, {24'd0, q[0]});
        chk("inst_data", {16'd0, inst_data}, {16'd0, word_of(q[0])});
      end
    end
    rsp = reset && !hold && mq.size() > 0 && mq[0].due <= cyc;
    resp_valid = rsp;
    resp_data  = rsp ? word_of(mq[0].pc) : 16'h0;
    if (inst_valid && inst_ready && reset && !redirect_valid)
      got.push_back(inst_pc);
    if (!reset) begin
      mq.delete();
      q.delete();
      m_fetch = '0;
      armed   = 1'b1;
    end else begin
      acc = erv && req_ready;
      pop = q.size() != 0 && inst_ready;
      if (rsp) e = mq.pop_front();
      if (redirect_valid) begin
        q.delete();
        m_fetch = redirect_pc;
        epoch++;
      end else begin
        if (pop) void'(q.pop_front());
        if (rsp && e.ep == epoch) q.push_back(e.pc);
        if (acc) begin
          mq.push_back('{pc: m_fetch, ep: epoch, due: cyc + lat});
          m_fetch = m_fetch + 8'd1;
        end
      end
    end
    cyc++;
  end

  task automatic ticks(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    req_ready = 1'b1;
    inst_ready = 1'b1;
    ticks(2);
    chk("rst_req_valid", {31'd0, req_valid}, 0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 0);
    chk("rst_req_addr", {24'd0, req_addr}, 0);
    chk("rst_inst_pc", {24'd0, inst_pc}, 0);
    chk("rst_inst_data", {16'd0, inst_data}, 0);

    // 1: free-running, 1-cycle memory
    mark = got.size();
    reset = 1'b1;
    ticks(8);
    chk("t1_count", got.size() - mark, 6);
    for (int i = 0; i < 4; i++) chk("t1_pc", {24'd0, g(i)}, i);

    // 2: decode stalled, queue fills to 4
    reset = 1'b0;
    inst_ready = 1'b0;
    ticks(1);
    reset = 1'b1;
    mark = got.size();
    ticks(8);
    chk("t2_req_stopped", {31'd0, req_valid}, 0);
    chk("t2_inst_valid", {31'd0, inst_valid}, 1);
    chk("t2_no_pops", got.size() - mark, 0);
    inst_ready = 1'b1;
    ticks(6);
    chk("t2_enough", {31'd0, got.size() - mark >= 5}, 1);
    for (int i = 0; i < 5; i++) chk("t2_pc", {24'd0, g(i)}, i);

    // 3: redirect with two reads held in flight
    reset = 1'b0;
    lat = 2;
    hold = 1'b1;
    ticks(1);
    reset = 1'b1;
    ticks(3);
    mark = got.size();
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    #1;
    chk("t3_no_issue_redirect", {31'd0, req_valid}, 0);
    ticks(1);
    redirect_valid = 1'b0;
    hold = 1'b0;
    ticks(12);
    chk("t3_pc0", {24'd0, g(0)}, 32'h40);
    chk("t3_pc1", {24'd0, g(1)}, 32'h41);

    // 4: wrap of the fetch address
    lat = 1;
    mark = got.size();
    redirect_valid = 1'b1;
    redirect_pc = 8'hFE;
    ticks(1);
    redirect_valid = 1'b0;
    ticks(10);
    chk("t4_pc0", {24'd0, g(0)}, 32'hFE);
    chk("t4_pc1", {24'd0, g(1)}, 32'hFF);
    chk("t4_pc2", {24'd0, g(2)}, 32'h00);
    chk("t4_pc3", {24'd0, g(3)}, 32'h01);

    // 5a: redirect meeting a response, then a second redirect
    reset = 1'b0;
    lat = 2;
    hold = 1'b1;
    ticks(1);
    reset = 1'b1;
    ticks(3);
    mark = got.size();
    hold = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 8'h80;
    ticks(1);
    hold = 1'b1;
    redirect_pc = 8'h90;
    ticks(1);
    redirect_valid = 1'b0;
    hold = 1'b0;
    ticks(12);
    chk("t5a_pc0", {24'd0, g(0)}, 32'h90);
    chk("t5a_pc1", {24'd0, g(1)}, 32'h91);

    // 5b: back-to-back redirects on a busy 1-cycle stream
    lat = 1;
    ticks(6);
    mark = got.size();
    redirect_valid = 1'b1;
    redirect_pc = 8'h10;
    ticks(1);
    redirect_pc = 8'h20;
    ticks(1);
    redirect_valid = 1'b0;
    ticks(8);
    chk("t5b_pc0", {24'd0, g(0)}, 32'h20);
    chk("t5b_pc1", {24'd0, g(1)}, 32'h21);

    // 6: reset with a full queue
    inst_ready = 1'b0;
    ticks(8);
    chk("t6_full_valid", {31'd0, inst_valid}, 1);
    reset = 1'b0;
    ticks(1);
    chk("t6_inst_valid", {31'd0, inst_valid}, 0);
    chk("t6_req_valid", {31'd0, req_valid}, 0);
    mark = got.size();
    reset = 1'b1;
    inst_ready = 1'b1;
    ticks(8);
    chk("t6_pc0", {24'd0, g(0)}, 0);
    chk("t6_pc1", {24'd0, g(1)}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
